// File: rtl/vscale_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single backend memory port.
// One transaction in flight at a time; store data is captured one cycle after the store address.
module vscale_mem_arbiter #(
    parameter int XPR_LEN        = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               i_req_valid,
    input  logic [XPR_LEN-1:0] i_req_addr,
    output logic               i_req_ready,
    output logic               i_resp_valid,
    output logic [XPR_LEN-1:0] i_resp_rdata,
    output logic               i_resp_badmem,

    input  logic               d_req_valid,
    input  logic               d_req_wen,
    input  logic [2:0]         d_req_size,
    input  logic [XPR_LEN-1:0] d_req_addr,
    output logic               d_req_ready,
    input  logic [XPR_LEN-1:0] d_wdata,
    output logic               d_resp_valid,
    output logic [XPR_LEN-1:0] d_resp_rdata,
    output logic               d_resp_badmem,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [XPR_LEN-1:0] mem_req_addr,
    output logic               mem_req_wen,
    output logic [2:0]         mem_req_size,
    output logic [XPR_LEN-1:0] mem_req_wdata,
    input  logic               mem_resp_valid,
    input  logic [XPR_LEN-1:0] mem_resp_rdata,
    input  logic               mem_resp_badmem
);

    typedef enum logic [1:0] {IDLE, WDATA, ISSUE, WAIT} state_t;
    typedef enum logic {REQ_I, REQ_D} req_t;

    state_t             state_q;
    req_t               owner_q;
    req_t               last_grant_q;
    logic [XPR_LEN-1:0] addr_q;
    logic [XPR_LEN-1:0] wdata_q;
    logic               wen_q;
    logic [2:0]         size_q;

    logic grant_d;
    logic grant_i;
    logic in_idle;
    logic resp_fire;

    // D wins when alone, or on a tie when D is prioritised or I was served last.
    assign grant_d = d_req_valid &&
                     (!i_req_valid || (FIXED_PRIORITY != 0) || (last_grant_q == REQ_I));
    assign grant_i = i_req_valid && !grant_d;

    // Handshake and strobe outputs are masked by reset so nothing fires while it is held.
    assign in_idle     = (state_q == IDLE) && !reset;
    assign i_req_ready = in_idle && grant_i;
    assign d_req_ready = in_idle && grant_d;

    assign resp_fire     = (state_q == WAIT) && mem_resp_valid && !reset;
    assign i_resp_valid  = resp_fire && (owner_q == REQ_I);
    assign d_resp_valid  = resp_fire && (owner_q == REQ_D);
    assign i_resp_rdata  = mem_resp_rdata;
    assign d_resp_rdata  = mem_resp_rdata;
    assign i_resp_badmem = mem_resp_badmem;
    assign d_resp_badmem = mem_resp_badmem;

    assign mem_req_valid = (state_q == ISSUE) && !reset;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_size  = size_q;
    assign mem_req_wdata = wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= REQ_I;
            last_grant_q <= REQ_I;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            size_q       <= 3'd0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        addr_q       <= d_req_addr;
                        wen_q        <= d_req_wen;
                        size_q       <= d_req_size;
                        owner_q      <= REQ_D;
                        last_grant_q <= REQ_D;
                        state_q      <= d_req_wen ? WDATA : ISSUE;
                    end else if (grant_i) begin
                        addr_q       <= i_req_addr;
                        wen_q        <= 1'b0;
                        size_q       <= 3'd0;
                        owner_q      <= REQ_I;
                        last_grant_q <= REQ_I;
                        state_q      <= ISSUE;
                    end
                end
                WDATA: begin
                    wdata_q <= d_wdata;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (mem_req_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_resp_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter: a round-robin instance and a fixed-priority instance
// share the same stimulus; a vector table covers whole transactions, hand sequences the corners.
module tb_vscale_mem_arbiter;

    localparam logic [31:0] JUNK = 32'h5555_5555;

    logic        clk;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        d_req_valid;
    logic        d_req_wen;
    logic [2:0]  d_req_size;
    logic [31:0] d_req_addr;
    logic [31:0] d_wdata;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_badmem;

    logic        i_req_ready, i_resp_valid, i_resp_badmem;
    logic [31:0] i_resp_rdata;
    logic        d_req_ready, d_resp_valid, d_resp_badmem;
    logic [31:0] d_resp_rdata;
    logic        mem_req_valid, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [2:0]  mem_req_size;

    logic        fp_i_req_ready, fp_i_resp_valid, fp_i_resp_badmem;
    logic [31:0] fp_i_resp_rdata;
    logic        fp_d_req_ready, fp_d_resp_valid, fp_d_resp_badmem;
    logic [31:0] fp_d_resp_rdata;
    logic        fp_mem_req_valid, fp_mem_req_wen;
    logic [31:0] fp_mem_req_addr, fp_mem_req_wdata;
    logic [2:0]  fp_mem_req_size;

    int n_checks = 0;
    int n_fail   = 0;

    vscale_mem_arbiter #(.XPR_LEN(32), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_resp_badmem(i_resp_badmem),
        .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_size(d_req_size),
        .d_req_addr(d_req_addr), .d_req_ready(d_req_ready), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_badmem(d_resp_badmem),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_badmem(mem_resp_badmem)
    );

    vscale_mem_arbiter #(.XPR_LEN(32), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(fp_i_req_ready),
        .i_resp_valid(fp_i_resp_valid), .i_resp_rdata(fp_i_resp_rdata),
        .i_resp_badmem(fp_i_resp_badmem),
        .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_size(d_req_size),
        .d_req_addr(d_req_addr), .d_req_ready(fp_d_req_ready), .d_wdata(d_wdata),
        .d_resp_valid(fp_d_resp_valid), .d_resp_rdata(fp_d_resp_rdata),
        .d_resp_badmem(fp_d_resp_badmem),
        .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(fp_mem_req_addr), .mem_req_wen(fp_mem_req_wen),
        .mem_req_size(fp_mem_req_size), .mem_req_wdata(fp_mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_badmem(mem_resp_badmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        iv;
        logic        dv;
        logic        dwen;
        logic [2:0]  dsize;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        bad;
        logic        exp_d;      // round-robin instance grants D
        logic        fp_d;       // fixed-priority instance grants D
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, checks happen at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        i_req_valid    = v.iv;
        d_req_valid    = v.dv;
        i_req_addr     = v.iaddr;
        d_req_addr     = v.daddr;
        d_req_wen      = v.dwen;
        d_req_size     = v.dsize;
        d_wdata        = JUNK;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        #4;
        check_bit({t, ".i_ready"}, i_req_ready, v.iv && !v.exp_d);
        check_bit({t, ".d_ready"}, d_req_ready, v.exp_d);
        check_bit({t, ".fp_i_ready"}, fp_i_req_ready, v.iv && !v.fp_d);
        check_bit({t, ".fp_d_ready"}, fp_d_req_ready, v.fp_d);
        check_bit({t, ".idle_memv"}, mem_req_valid, 1'b0);
        step();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        if (v.exp_d && v.dwen) begin
            d_wdata = v.wdata;
            #4;
            check_bit({t, ".wdata_memv"}, mem_req_valid, 1'b0);
            step();
            d_wdata = JUNK;
        end
        #4;
        check_bit({t, ".memv"}, mem_req_valid, 1'b1);
        check({t, ".addr"}, mem_req_addr, v.exp_addr);
        check_bit({t, ".wen"}, mem_req_wen, v.exp_d && v.dwen);
        check({t, ".size"}, {29'b0, mem_req_size}, {29'b0, v.exp_size});
        check({t, ".wdata"}, mem_req_wdata, v.exp_wdata);
        step();
        mem_resp_valid  = 1'b1;
        mem_resp_rdata  = v.rdata;
        mem_resp_badmem = v.bad;
        #4;
        check_bit({t, ".wait_memv"}, mem_req_valid, 1'b0);
        check_bit({t, ".i_resp"}, i_resp_valid, !v.exp_d);
        check_bit({t, ".d_resp"}, d_resp_valid, v.exp_d);
        check_bit({t, ".fp_d_resp"}, fp_d_resp_valid, v.fp_d);
        check_bit({t, ".fp_i_resp"}, fp_i_resp_valid, !v.fp_d);
        check({t, ".rdata"}, v.exp_d ? d_resp_rdata : i_resp_rdata, v.rdata);
        check_bit({t, ".badmem"}, v.exp_d ? d_resp_badmem : i_resp_badmem, v.bad);
        step();
        mem_resp_valid  = 1'b0;
        mem_resp_badmem = 1'b0;
    endtask

    initial begin
        //            iv    dv    wen   size  iaddr          daddr          wdata          rdata          bad   exp_d fp_d  exp_addr       size  exp_wdata
        vecs[0] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0000_0400, 32'h0,         32'h1111_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 3'd2, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0304, 32'h0000_0404, 32'h0,         32'h2222_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 3'd0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_0308, 32'h0000_0408, 32'h0,         32'hBAD0_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0408, 3'd1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_030C, 32'h0000_040C, 32'h0,         32'h4444_0000, 1'b0, 1'b0, 1'b1, 32'h0000_030C, 3'd0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0200, 32'h0,         32'h0,         32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 3'd0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 3'd2, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0204, 32'h0,         32'h0,         32'h0000_0093, 1'b0, 1'b0, 1'b0, 32'h0000_0204, 3'd0, 32'hDEAD_BEEF};

        reset           = 1'b1;
        i_req_valid     = 1'b1;
        d_req_valid     = 1'b1;
        i_req_addr      = 32'h0;
        d_req_addr      = 32'h0;
        d_req_wen       = 1'b0;
        d_req_size      = 3'd0;
        d_wdata         = JUNK;
        mem_req_ready   = 1'b1;
        mem_resp_valid  = 1'b0;
        mem_resp_rdata  = 32'h0;
        mem_resp_badmem = 1'b0;
        step();
        step();
        #4;
        check_bit("rst.i_ready", i_req_ready, 1'b0);
        check_bit("rst.d_ready", d_req_ready, 1'b0);
        check_bit("rst.memv", mem_req_valid, 1'b0);
        check("rst.addr", mem_req_addr, 32'h0);
        check("rst.wdata", mem_req_wdata, 32'h0);
        check_bit("rst.wen", mem_req_wen, 1'b0);
        step();
        reset       = 1'b0;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;

        for (int k = 0; k < 7; k++) txn(vecs[k], k);

        // Store stalled three cycles by the backend, with a fetch waiting and a stray response in ISSUE.
        i_req_valid   = 1'b1;
        i_req_addr    = 32'h0000_0500;
        d_req_valid   = 1'b1;
        d_req_wen     = 1'b1;
        d_req_size    = 3'd2;
        d_req_addr    = 32'h0000_0120;
        mem_req_ready = 1'b0;
        #4;
        check_bit("stall.d_ready", d_req_ready, 1'b1);
        check_bit("stall.i_ready", i_req_ready, 1'b0);
        step();
        d_req_valid = 1'b0;
        d_wdata     = 32'hCAFE_F00D;
        #4;
        check_bit("stall.wd_i_ready", i_req_ready, 1'b0);
        step();
        d_wdata = JUNK;
        for (int c = 0; c < 3; c++) begin
            mem_resp_valid = (c == 1);
            #4;
            check_bit("stall.memv", mem_req_valid, 1'b1);
            check("stall.addr", mem_req_addr, 32'h0000_0120);
            check_bit("stall.wen", mem_req_wen, 1'b1);
            check("stall.size", {29'b0, mem_req_size}, 32'd2);
            check("stall.wdata", mem_req_wdata, 32'hCAFE_F00D);
            check_bit("stall.i_ready_hold", i_req_ready, 1'b0);
            check_bit("stall.d_resp", d_resp_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #4;
        check_bit("stall.hs_memv", mem_req_valid, 1'b1);
        step();
        #4;
        check_bit("stall.one_hs", mem_req_valid, 1'b0);
        check_bit("stall.wait_i_ready", i_req_ready, 1'b0);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0;
        #4;
        check_bit("stall.d_resp_done", d_resp_valid, 1'b1);
        check_bit("stall.i_resp_none", i_resp_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        #4;
        check_bit("stall.i_granted", i_req_ready, 1'b1);
        step();
        i_req_valid = 1'b0;
        #4;
        check("stall.f_addr", mem_req_addr, 32'h0000_0500);
        check_bit("stall.f_wen", mem_req_wen, 1'b0);
        check("stall.f_wdata_held", mem_req_wdata, 32'hCAFE_F00D);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0077;
        #4;
        check_bit("stall.f_resp", i_resp_valid, 1'b1);
        check("stall.f_rdata", i_resp_rdata, 32'h0000_0077);
        step();
        mem_resp_valid = 1'b0;

        // Reset while waiting for a response, then a stray response, then a clean fetch.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0600;
        #4;
        check_bit("mrst.i_ready", i_req_ready, 1'b1);
        step();
        #4;
        check("mrst.addr", mem_req_addr, 32'h0000_0600);
        step();
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0099;
        #4;
        check_bit("mrst.i_resp", i_resp_valid, 1'b0);
        check_bit("mrst.d_resp", d_resp_valid, 1'b0);
        check_bit("mrst.i_ready", i_req_ready, 1'b0);
        step();
        reset       = 1'b0;
        i_req_valid = 1'b0;
        #4;
        check_bit("stray.i_resp", i_resp_valid, 1'b0);
        check_bit("stray.d_resp", d_resp_valid, 1'b0);
        check_bit("stray.memv", mem_req_valid, 1'b0);
        check("stray.addr", mem_req_addr, 32'h0);
        step();
        mem_resp_valid = 1'b0;
        i_req_valid    = 1'b1;
        i_req_addr     = 32'h0000_0700;
        #4;
        check_bit("post.i_ready", i_req_ready, 1'b1);
        step();
        i_req_valid = 1'b0;
        #4;
        check_bit("post.memv", mem_req_valid, 1'b1);
        check("post.addr", mem_req_addr, 32'h0000_0700);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0013;
        #4;
        check_bit("post.i_resp", i_resp_valid, 1'b1);
        check("post.rdata", i_resp_rdata, 32'h0000_0013);
        check_bit("post.d_resp", d_resp_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_mem_arbiter.md
Name: vscale_mem_arbiter

Overview:
Shares one backend memory port between the core's instruction-fetch requester (I) and data requester (D). Only one transaction is outstanding at a time. Arbitration is round-robin, with an optional fixed D priority. Store data is accepted one cycle after the store address, matching the core's delayed-wdata timing. The block sits between vscale_core's imem/dmem side and a single-ported memory or bus bridge.

Parameters:
XPR_LEN, 32, address/data width
FIXED_PRIORITY, 0, 1 = D always wins a tie; 0 = round-robin

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req_valid  in  1  fetch request
i_req_addr  in  XPR_LEN  fetch address
i_req_ready  out  1  fetch request accepted this cycle
i_resp_valid  out  1  fetch response strobe
i_resp_rdata  out  XPR_LEN  fetch data
i_resp_badmem  out  1  fetch bus error
d_req_valid  in  1  data request
d_req_wen  in  1  1 = store
d_req_size  in  3  access size, MEM_TYPE encoding, passed through unmodified
d_req_addr  in  XPR_LEN  data address
d_req_ready  out  1  data request accepted this cycle
d_wdata  in  XPR_LEN  store data, valid the cycle after store acceptance
d_resp_valid  out  1  data response strobe (loads and stores)
d_resp_rdata  out  XPR_LEN  load data
d_resp_badmem  out  1  data bus error
mem_req_valid  out  1  backend request
mem_req_ready  in  1  backend accepts request
mem_req_addr  out  XPR_LEN  backend address
mem_req_wen  out  1  backend write enable
mem_req_size  out  3  backend size
mem_req_wdata  out  XPR_LEN  backend write data
mem_resp_valid  in  1  backend response
mem_resp_rdata  in  XPR_LEN  backend read data
mem_resp_badmem  in  1  backend error

Behaviour:
- States: IDLE, WDATA, ISSUE, WAIT. Registers: state, owner (I/D), last_grant, addr, wen, size, wdata.
- IDLE: winner chosen combinationally; winner's req_ready=1 and the loser's is 0; no ready asserted anywhere outside IDLE.
  - Single valid requester wins.
  - Tie, FIXED_PRIORITY=1: D wins.
  - Tie, FIXED_PRIORITY=0: the requester not equal to last_grant wins.
  - On accept: latch addr/wen/size (wen=0, size=0 for I), set owner, update last_grant.
  - Next state: WDATA if D store, otherwise ISSUE.
- WDATA: latch d_wdata unconditionally, go to ISSUE. wdata is held at its last value for loads and fetches.
- ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready. On handshake go to WAIT.
- WAIT: mem_req_valid=0.
  - On mem_resp_valid: owner's resp_valid=1 for exactly that cycle; rdata/badmem pass through combinationally from mem_resp_*; go to IDLE.
  - Non-owner resp_valid stays 0.
- resp_rdata/badmem outputs: drive mem_resp_* always; meaningful only when resp_valid=1.
- mem_resp_valid outside WAIT is ignored; no state change.
- The backend must not return a response in the same cycle as its request handshake. Responses in ISSUE are ignored.
- Latency, zero backend wait (request accepted cycle T, response at T+2 earliest):
  - Load/fetch: mem_req handshake at T+1, response earliest T+2, IDLE at T+3.
  - Store: handshake at T+2, response earliest T+3, IDLE at T+4.
- Requests are not queued. A requester not granted keeps req_valid high; its fields may change while it is not ready.
- Reset: state=IDLE, last_grant=I (first tie goes to D), owner=I, addr/wen/size/wdata=0.
  - All ready and resp_valid outputs and mem_req_valid are 0 during any cycle with reset high.
- Reset mid-transaction: the outstanding transaction is abandoned with no response; a later stray mem_resp_valid is ignored.
- mem_req_addr/wen/size/wdata come directly from registers. No combinational path from any i_/d_ input to any mem_req_* output.

Test Plan:
- Fetch alone, addr 0x200, mem_req_ready=1, resp next cycle with rdata 0x00000013:
  - i_req_ready at T, mem_req_valid at T+1, i_resp_valid at T+2 with 0x00000013.
  - d_resp_valid stays 0 throughout.
- Store 0x100, size word, d_wdata 0xDEADBEEF presented at T+1:
  - mem_req_valid at T+2 with addr 0x100, wen=1, wdata 0xDEADBEEF.
  - d_resp_valid when the response returns.
- I and D both valid continuously, FIXED_PRIORITY=0:
  - Grants after reset alternate D, I, D, I.
  - With FIXED_PRIORITY=1, every grant is D.
- Backend holds mem_req_ready=0 for 3 cycles:
  - mem_req_addr/wen/size/wdata stay constant through the stall.
  - Exactly one handshake occurs; no ready asserted during the stall.
- Load response with mem_resp_badmem=1: d_resp_valid=1, d_resp_badmem=1; i_resp_valid=0.
- Reset in WAIT followed by a stray mem_resp_valid: no resp_valid on either port; state IDLE; next fetch completes normally.
